// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter draining an upstream synchronous FIFO, 8 data bits,
// optional even/odd parity, one stop bit; one pop per frame, issued only from IDLE.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
    localparam logic ODD = (PARITY == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          bit_end;

    assign bit_end    = (cnt_q == LAST);
    // Gated by reset so no pop can be requested while the FSM is held in reset
    assign fifo_rd_en = reset_n && (state_q == S_IDLE) && !fifo_empty;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = fifo_empty ? S_IDLE : S_FETCH;
            end
            S_FETCH: begin
                shift_d = fifo_data;
                par_d   = ^fifo_data ^ ODD;
                cnt_d   = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: if (bit_end) begin
                state_d = S_DATA;
                tx_d    = shift_q[0];
                idx_d   = '0;
            end
            S_DATA: if (bit_end) begin
                shift_d = {1'b0, shift_q[7:1]};
                idx_d   = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
                state_d = (idx_q != 3'd7) ? S_DATA : HAS_PAR ? S_PARITY : S_STOP;
                tx_d    = (idx_q != 3'd7) ? shift_q[1] : HAS_PAR ? par_q : 1'b1;
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
            S_STOP: if (bit_end) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end
endmodule
